// File: rtl/lane_data_mem.sv
// Lane-packed data memory: one core read/write port with per-lane write mask and
// a dump sequencer streaming rows (or single lanes) out over valid/ready.
module lane_data_mem_bank #(
  parameter int W  = 12,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic          dump_rd,
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] dump_addr,
  input  logic [W-1:0]  wr_data,
  output logic [W-1:0]  rd_word,
  output logic [W-1:0]  dump_word
);
  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk)
    if (wr_en) mem[addr] <= wr_data;

  // Both read registers sample before the write lands, giving read-first behaviour.
  always_ff @(posedge clk)
    if (rst) begin
      rd_word   <= '0;
      dump_word <= '0;
    end else begin
      if (rd_en)   rd_word   <= mem[addr];
      if (dump_rd) dump_word <= mem[dump_addr];
    end
endmodule

module lane_data_mem #(
  parameter int LANE_WIDTH = 12,
  parameter int LANE_COUNT = 3,
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic                             rd_en,
  input  logic                             wr_en,
  input  logic [LANE_COUNT-1:0]            wr_mask,
  input  logic [LANE_COUNT*LANE_WIDTH-1:0] wr_data,
  output logic [LANE_COUNT*LANE_WIDTH-1:0] rd_data,
  output logic                             rd_valid,
  input  logic                             dump_start,
  input  logic [ADDR_WIDTH-1:0]            dump_base,
  input  logic [ADDR_WIDTH-1:0]            dump_len,
  input  logic                             dump_lane_mode,
  output logic                             dump_valid,
  input  logic                             dump_ready,
  output logic [LANE_COUNT*LANE_WIDTH-1:0] dump_data,
  output logic [ADDR_WIDTH-1:0]            dump_addr,
  output logic [(LANE_COUNT>1 ? $clog2(LANE_COUNT) : 1)-1:0] dump_lane,
  output logic                             dump_last,
  output logic                             busy
);
  localparam int ROW_W  = LANE_COUNT*LANE_WIDTH;
  localparam int LIDX_W = (LANE_COUNT > 1) ? $clog2(LANE_COUNT) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] cur_addr, last_addr;
  logic                  lane_mode;
  logic [LIDX_W-1:0]     lane;
  logic [ROW_W-1:0]      core_row, dump_row;
  logic                  fetch, start_ok, at_last;

  assign fetch    = (state == FETCH);
  assign start_ok = dump_start && (dump_len != '0);
  assign at_last  = (cur_addr == last_addr);

  for (genvar g = 0; g < LANE_COUNT; g++) begin : g_lane
    lane_data_mem_bank #(.W(LANE_WIDTH), .AW(ADDR_WIDTH)) u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en & wr_mask[g]),
      .rd_en    (rd_en),
      .dump_rd  (fetch),
      .addr     (addr),
      .dump_addr(cur_addr),
      .wr_data  (wr_data[g*LANE_WIDTH +: LANE_WIDTH]),
      .rd_word  (core_row[g*LANE_WIDTH +: LANE_WIDTH]),
      .dump_word(dump_row[g*LANE_WIDTH +: LANE_WIDTH])
    );
  end

  logic [RD_LATENCY-1:0] vld_pipe;

  always_ff @(posedge clk)
    if (rst) vld_pipe <= '0;
    else begin
      vld_pipe[0] <= rd_en;
      for (int i = 1; i < RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end

  assign rd_valid = vld_pipe[RD_LATENCY-1];

  // Extra stages only advance with a valid read, so rd_data holds between reads.
  if (RD_LATENCY == 1) begin : g_lat1
    assign rd_data = core_row;
  end else begin : g_latn
    logic [ROW_W-1:0] dpipe [RD_LATENCY-1];
    always_ff @(posedge clk)
      if (rst) begin
        for (int k = 0; k < RD_LATENCY-1; k++) dpipe[k] <= '0;
      end else begin
        if (vld_pipe[0]) dpipe[0] <= core_row;
        for (int k = 1; k < RD_LATENCY-1; k++)
          if (vld_pipe[k]) dpipe[k] <= dpipe[k-1];
      end
    assign rd_data = dpipe[RD_LATENCY-2];
  end

  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = FETCH;
      FETCH:   state_nxt = PRESENT;
      PRESENT: if (dump_ready && !(lane_mode && lane != '0))
                 state_nxt = at_last ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (rst) begin
      cur_addr  <= '0;
      last_addr <= '0;
      lane_mode <= 1'b0;
      lane      <= '0;
    end else begin
      case (state)
        IDLE: if (start_ok) begin
          cur_addr  <= dump_base;
          last_addr <= dump_base + dump_len - ADDR_WIDTH'(1);
          lane_mode <= dump_lane_mode;
          lane      <= '0;
        end
        FETCH: lane <= lane_mode ? LIDX_W'(LANE_COUNT-1) : '0;
        PRESENT: if (dump_ready) begin
          if (lane_mode && lane != '0) lane     <= lane - LIDX_W'(1);
          else if (!at_last)           cur_addr <= cur_addr + ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end

  assign dump_valid = (state == PRESENT);
  assign busy       = (state != IDLE);
  assign dump_addr  = cur_addr;
  assign dump_lane  = lane;
  assign dump_last  = dump_valid && at_last && (!lane_mode || lane == '0);

  always_comb begin
    dump_data = '0;
    if (dump_valid) begin
      if (!lane_mode) dump_data = dump_row;
      else
        for (int i = 0; i < LANE_COUNT; i++)
          if (lane == LIDX_W'(i)) dump_data[LANE_WIDTH-1:0] = dump_row[i*LANE_WIDTH +: LANE_WIDTH];
    end
  end
endmodule

// File: doc/lane_data_mem.md
Name: lane_data_mem

Overview:
- Parametrised lane-packed data memory for the multi-core processor. One row holds LANE_COUNT lanes of LANE_WIDTH bits, one lane per core.
- Core side: one read/write port with per-lane write mask and configurable read latency.
- Dump side: an independent read sequencer streams an address range out over a valid/ready interface. It can emit whole rows or one lane per beat, so benches and host logic can extract result matrices in hardware.

Parameters:
- LANE_WIDTH, 12: bits per lane (core register width).
- LANE_COUNT, 3: lanes per row (core count).
- ADDR_WIDTH, 12: address bits; DEPTH = 2**ADDR_WIDTH rows.
- RD_LATENCY, 1: core read latency in cycles; legal range 1..4.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- addr  in  ADDR_WIDTH  core row address.
- rd_en  in  1  core read request.
- wr_en  in  1  core write request.
- wr_mask  in  LANE_COUNT  per-lane write enable; bit i selects lane i.
- wr_data  in  LANE_COUNT*LANE_WIDTH  write row; lane i = bits [(i+1)*LANE_WIDTH-1 -: LANE_WIDTH].
- rd_data  out  LANE_COUNT*LANE_WIDTH  core read row.
- rd_valid  out  1  rd_data valid this cycle.
- dump_start  in  1  start dump (pulse).
- dump_base  in  ADDR_WIDTH  first row of dump.
- dump_len  in  ADDR_WIDTH  number of rows to dump.
- dump_lane_mode  in  1  0 = one row per beat; 1 = one lane per beat.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  consumer accepts beat.
- dump_data  out  LANE_COUNT*LANE_WIDTH  beat data. In lane mode the selected lane sits in bits [LANE_WIDTH-1:0] and the upper bits are zero.
- dump_addr  out  ADDR_WIDTH  row address of current beat.
- dump_lane  out  max(1,$clog2(LANE_COUNT))  lane index of current beat; 0 in row mode.
- dump_last  out  1  final beat of the dump.
- busy  out  1  dump in progress.

Behaviour:
- Reset:
  - Clears rd_data, rd_valid, the latency pipeline, dump_valid, dump_data, dump_addr, dump_lane, dump_last and busy to 0.
  - FSM goes to IDLE.
  - Memory contents are not cleared.
- Core write:
  - When wr_en=1 at an edge, every lane i with wr_mask[i]=1 takes its lane of wr_data; masked-off lanes keep their contents.
  - wr_en with wr_mask=0 is a no-op.
- Core read:
  - rd_en sampled at edge N gives rd_data/rd_valid=1 after edge N+RD_LATENCY-1 (RD_LATENCY=1: registered, visible the cycle after the request).
  - rd_data holds its last value when rd_valid=0.
  - rd_en and wr_en may both be asserted on the same address: read returns the old contents (read-first).
- Dump FSM states: IDLE, FETCH, PRESENT.
  - IDLE: dump_start=1 and dump_len!=0 → latch base/len/mode, busy=1, go to FETCH. dump_start with dump_len=0 is ignored (busy stays 0).
  - FETCH: one cycle; the internal dump read port reads row cur_addr; go to PRESENT. In lane mode, lane = LANE_COUNT-1.
  - PRESENT:
    - dump_valid=1. dump_data, dump_addr, dump_lane and dump_last stay stable until dump_ready=1.
    - On handshake in lane mode with lane>0: decrement lane, stay in PRESENT, no refetch.
    - Otherwise, if this beat was last: go to IDLE, dump_valid=0, busy=0 on the next cycle.
    - Else cur_addr+1, go to FETCH.
  - dump_last=1 only on the beat with row = base+len-1. In lane mode it is additionally qualified by lane 0.
- Address arithmetic is modulo DEPTH: a dump crossing DEPTH-1 wraps to row 0.
- dump_start while busy=1 is ignored.
- Core port stays fully functional during a dump. A core write in the same cycle as a FETCH of the same row is not seen by that fetch (old data). Later fetches see the write.
- rst mid-dump: the dump aborts, with dump_valid=0 and busy=0 the next cycle. No partial beat is emitted.

Test Plan:
- Masked write: write row 5 = {12'h111,12'h222,12'h333} with mask 3'b111, then {12'hAAA,12'hBBB,12'hCCC} with mask 3'b010 → read row 5 returns {12'h111,12'hBBB,12'h333}.
- Latency sweep: RD_LATENCY=1 and 3, rd_en at addr 7 at edge N → rd_valid high exactly at edge N+RD_LATENCY-1 with the correct row; read+write on the same address returns the old value.
- Row dump: base=10, len=3, dump_ready always 1 → 3 beats for addr 10,11,12, dump_last only on addr 12, busy drops the cycle after.
- Lane dump with backpressure: base=0, len=2, lane mode, dump_ready toggling 1/0 → 6 beats ordered (0,2),(0,1),(0,0),(1,2),(1,1),(1,0). Data is held stable while ready=0; dump_last only on (1,0).
- Wrap and zero length: base=4094, len=4 → addresses 4094,4095,0,1. A dump_start with len=0 leaves busy=0 and no beats.
- Reset mid-dump: assert rst during the 2nd beat of a len=8 dump → dump_valid=0, busy=0 next cycle. Memory is unchanged, verified by core reads afterward.
